// File: rtl/aes_gcm_input_scheduler.sv
// ============================================================================
// Module   : aes_gcm_input_scheduler
// Purpose  : Turns one GCM instance (IV, lengths, block stream) into ordered
//            stage-1 beats: AAD blocks, PT blocks, then one length beat.
// Revision : 1.0
// ============================================================================
`default_nettype none

module aes_gcm_input_scheduler #(
  parameter logic [1:0] PHASE_AAD  = 2'd0,
  parameter logic [1:0] PHASE_PT   = 2'd1,
  parameter logic [1:0] PHASE_LEN  = 2'd2,
  parameter logic [1:0] PHASE_IDLE = 2'd3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [95:0]  i_iv,
  input  logic [63:0]  i_aad_bits,
  input  logic [63:0]  i_pt_bits,
  output logic         o_start_ready,
  input  logic         i_blk_valid,
  input  logic [127:0] i_blk_data,
  output logic         o_blk_ready,
  output logic         o_valid,
  output logic [1:0]   o_phase,
  output logic [127:0] o_aad,
  output logic [127:0] o_plain_text,
  output logic [127:0] o_j0,
  output logic [127:0] o_cb,
  output logic [127:0] o_instance_size,
  output logic         o_new_instance,
  output logic         o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AAD  = 2'd1,
    S_PT   = 2'd2,
    S_LEN  = 2'd3
  } state_t;

  state_t         state_q;
  logic [57:0]    na_q;
  logic [57:0]    np_q;
  logic [127:0]   cb_q;
  logic [127:0]   j0_q;
  logic [127:0]   size_q;
  logic           first_q;
  logic           valid_q;
  logic [1:0]     phase_q;
  logic [127:0]   aad_q;
  logic [127:0]   pt_q;
  logic [127:0]   cb_out_q;
  logic           new_q;

  // Ceiling divide by 128 without a 65-bit intermediate.
  logic [57:0]    w_na;
  logic [57:0]    w_np;
  logic [127:0]   w_j0;
  logic [127:0]   w_cb_d;

  assign w_na   = {1'b0, i_aad_bits[63:7]} + {57'd0, |i_aad_bits[6:0]};
  assign w_np   = {1'b0, i_pt_bits[63:7]}  + {57'd0, |i_pt_bits[6:0]};
  assign w_j0   = {i_iv, 31'd0, 1'b1};
  assign w_cb_d = {cb_q[127:32], cb_q[31:0] + 32'd1};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      na_q     <= '0;
      np_q     <= '0;
      cb_q     <= '0;
      j0_q     <= '0;
      size_q   <= '0;
      first_q  <= 1'b0;
      valid_q  <= 1'b0;
      phase_q  <= PHASE_IDLE;
      aad_q    <= '0;
      pt_q     <= '0;
      cb_out_q <= '0;
      new_q    <= 1'b0;
    end else begin
      valid_q  <= 1'b0;
      phase_q  <= PHASE_IDLE;
      aad_q    <= '0;
      pt_q     <= '0;
      cb_out_q <= '0;
      new_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            j0_q    <= w_j0;
            cb_q    <= w_j0;
            size_q  <= {i_aad_bits, i_pt_bits};
            na_q    <= w_na;
            np_q    <= w_np;
            first_q <= 1'b1;
            if (w_na != 58'd0)      state_q <= S_AAD;
            else if (w_np != 58'd0) state_q <= S_PT;
            else                    state_q <= S_LEN;
          end
        end
        S_AAD: begin
          if (i_blk_valid) begin
            valid_q <= 1'b1;
            phase_q <= PHASE_AAD;
            aad_q   <= i_blk_data;
            new_q   <= first_q;
            first_q <= 1'b0;
            na_q    <= na_q - 58'd1;
            if (na_q == 58'd1) state_q <= (np_q != 58'd0) ? S_PT : S_LEN;
          end
        end
        S_PT: begin
          if (i_blk_valid) begin
            valid_q  <= 1'b1;
            phase_q  <= PHASE_PT;
            pt_q     <= i_blk_data;
            cb_out_q <= w_cb_d;
            cb_q     <= w_cb_d;
            new_q    <= first_q;
            first_q  <= 1'b0;
            np_q     <= np_q - 58'd1;
            if (np_q == 58'd1) state_q <= S_LEN;
          end
        end
        default: begin
          valid_q <= 1'b1;
          phase_q <= PHASE_LEN;
          new_q   <= first_q;
          first_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_start_ready   = (state_q == S_IDLE);
  assign o_busy          = (state_q != S_IDLE);
  assign o_blk_ready     = (state_q == S_AAD) || (state_q == S_PT);
  assign o_valid         = valid_q;
  assign o_phase         = phase_q;
  assign o_aad           = aad_q;
  assign o_plain_text    = pt_q;
  assign o_j0            = j0_q;
  assign o_cb            = cb_out_q;
  assign o_instance_size = size_q;
  assign o_new_instance  = new_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_gcm_input_scheduler.sv
// ============================================================================
// Module   : tb_aes_gcm_input_scheduler
// Purpose  : Directed self-checking bench for aes_gcm_input_scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_aes_gcm_input_scheduler;

  logic         clk;
  logic         rst;
  logic         i_start;
  logic [95:0]  i_iv;
  logic [63:0]  i_aad_bits;
  logic [63:0]  i_pt_bits;
  logic         o_start_ready;
  logic         i_blk_valid;
  logic [127:0] i_blk_data;
  logic         o_blk_ready;
  logic         o_valid;
  logic [1:0]   o_phase;
  logic [127:0] o_aad;
  logic [127:0] o_plain_text;
  logic [127:0] o_j0;
  logic [127:0] o_cb;
  logic [127:0] o_instance_size;
  logic         o_new_instance;
  logic         o_busy;

  int checks = 0;
  int errors = 0;

  aes_gcm_input_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .i_start         (i_start),
    .i_iv            (i_iv),
    .i_aad_bits      (i_aad_bits),
    .i_pt_bits       (i_pt_bits),
    .o_start_ready   (o_start_ready),
    .i_blk_valid     (i_blk_valid),
    .i_blk_data      (i_blk_data),
    .o_blk_ready     (o_blk_ready),
    .o_valid         (o_valid),
    .o_phase         (o_phase),
    .o_aad           (o_aad),
    .o_plain_text    (o_plain_text),
    .o_j0            (o_j0),
    .o_cb            (o_cb),
    .o_instance_size (o_instance_size),
    .o_new_instance  (o_new_instance),
    .o_busy          (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full beat check: valid, phase, data outputs and new-instance flag.
  task automatic chk_beat(input string tag, input logic v, input logic [1:0] ph,
                          input logic [127:0] aad, input logic [127:0] pt,
                          input logic [127:0] cb, input logic nw);
    chk({tag, ".valid"}, {127'd0, o_valid}, {127'd0, v});
    chk({tag, ".phase"}, {126'd0, o_phase}, {126'd0, ph});
    chk({tag, ".aad"},   o_aad, aad);
    chk({tag, ".pt"},    o_plain_text, pt);
    chk({tag, ".cb"},    o_cb, cb);
    chk({tag, ".new"},   {127'd0, o_new_instance}, {127'd0, nw});
  endtask

  task automatic chk_ctl(input string tag, input logic sr, input logic bsy, input logic br);
    chk({tag, ".start_ready"}, {127'd0, o_start_ready}, {127'd0, sr});
    chk({tag, ".busy"},        {127'd0, o_busy},        {127'd0, bsy});
    chk({tag, ".blk_ready"},   {127'd0, o_blk_ready},   {127'd0, br});
  endtask

  logic [95:0]  iv3;
  logic [95:0]  iv5;
  logic [127:0] blk [0:4];

  initial begin
    rst = 1'b1; i_start = 1'b0; i_iv = '0; i_aad_bits = '0; i_pt_bits = '0;
    i_blk_valid = 1'b0; i_blk_data = '0;
    for (int k = 0; k < 5; k++) blk[k] = {4{32'hA5A50000 + 32'(k)}};
    step(); step();
    rst = 1'b0;
    step();

    // Idle after reset
    chk_beat("rst", 1'b0, 2'd3, '0, '0, '0, 1'b0);
    chk_ctl("rst", 1'b1, 1'b0, 1'b0);
    chk("rst.j0", o_j0, '0);
    chk("rst.size", o_instance_size, '0);

    // Instance 1: iv=0, nA=2, nP=3, back-to-back blocks
    i_iv = '0; i_aad_bits = 64'd256; i_pt_bits = 64'd384; i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk_ctl("t1.aad", 1'b0, 1'b1, 1'b1);
    chk("t1.novalid", {127'd0, o_valid}, 128'd0);
    chk("t1.j0", o_j0, 128'h1);
    chk("t1.size", o_instance_size, {64'd256, 64'd384});
    i_blk_valid = 1'b1;
    i_blk_data = blk[0]; step();
    chk_beat("t1.b0", 1'b1, 2'd0, blk[0], '0, '0, 1'b1);
    i_blk_data = blk[1]; step();
    chk_beat("t1.b1", 1'b1, 2'd0, blk[1], '0, '0, 1'b0);
    i_blk_data = blk[2]; step();
    chk_beat("t1.b2", 1'b1, 2'd1, '0, blk[2], 128'h2, 1'b0);
    i_blk_data = blk[3]; step();
    chk_beat("t1.b3", 1'b1, 2'd1, '0, blk[3], 128'h3, 1'b0);
    i_blk_data = blk[4]; step();
    chk_beat("t1.b4", 1'b1, 2'd1, '0, blk[4], 128'h4, 1'b0);
    chk_ctl("t1.len", 1'b0, 1'b1, 1'b0);
    i_blk_valid = 1'b0; i_blk_data = '0;
    step();
    chk_beat("t1.len", 1'b1, 2'd2, '0, '0, '0, 1'b0);
    chk_ctl("t1.done", 1'b1, 1'b0, 1'b0);
    step();
    chk_beat("t1.idle", 1'b0, 2'd3, '0, '0, '0, 1'b0);
    chk("t1.j0hold", o_j0, 128'h1);

    // Instance 2: empty instance gives a lone LEN beat
    i_aad_bits = '0; i_pt_bits = '0; i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk_beat("t2.wait", 1'b0, 2'd3, '0, '0, '0, 1'b0);
    chk_ctl("t2.wait", 1'b0, 1'b1, 1'b0);
    step();
    chk_beat("t2.len", 1'b1, 2'd2, '0, '0, '0, 1'b1);
    chk_ctl("t2.len", 1'b1, 1'b0, 1'b0);
    step();
    chk_beat("t2.idle", 1'b0, 2'd3, '0, '0, '0, 1'b0);

    // Instance 3: PT only, nP=2 from 200 bits; upper 96 cb bits carry the IV
    iv3 = 96'hDEADBEEF_01234567_89ABCDEF;
    i_iv = iv3; i_aad_bits = '0; i_pt_bits = 64'd200; i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk_ctl("t3.pt", 1'b0, 1'b1, 1'b1);
    chk("t3.j0", o_j0, {iv3, 32'h1});
    i_blk_valid = 1'b1; i_blk_data = blk[0]; step();
    chk_beat("t3.b0", 1'b1, 2'd1, '0, blk[0], {iv3, 32'h2}, 1'b1);
    i_blk_data = blk[1]; step();
    chk_beat("t3.b1", 1'b1, 2'd1, '0, blk[1], {iv3, 32'h3}, 1'b0);
    i_blk_valid = 1'b0; i_blk_data = '0;
    step();
    chk_beat("t3.len", 1'b1, 2'd2, '0, '0, '0, 1'b0);
    chk("t3.size", o_instance_size, {64'd0, 64'd200});

    // Instance 4: gapped blocks, start pulsed while busy
    i_iv = 96'h1; i_aad_bits = 64'd1; i_pt_bits = 64'd128; i_start = 1'b1;
    step();
    chk_ctl("t4.aad", 1'b0, 1'b1, 1'b1);
    step();
    chk_beat("t4.gap0", 1'b0, 2'd3, '0, '0, '0, 1'b0);
    chk("t4.j0keep", o_j0, {96'h1, 32'h1});
    i_blk_valid = 1'b1; i_blk_data = blk[2]; step();
    chk_beat("t4.a0", 1'b1, 2'd0, blk[2], '0, '0, 1'b1);
    i_blk_valid = 1'b0; step();
    chk_beat("t4.gap1", 1'b0, 2'd3, '0, '0, '0, 1'b0);
    chk_ctl("t4.pt", 1'b0, 1'b1, 1'b1);
    i_start = 1'b0;
    i_blk_valid = 1'b1; i_blk_data = blk[3]; step();
    chk_beat("t4.p0", 1'b1, 2'd1, '0, blk[3], {96'h1, 32'h2}, 1'b0);
    i_blk_valid = 1'b0; i_blk_data = '0;
    step();
    chk_beat("t4.len", 1'b1, 2'd2, '0, '0, '0, 1'b0);
    chk("t4.size", o_instance_size, {64'd1, 64'd128});
    step();
    chk_beat("t4.idle", 1'b0, 2'd3, '0, '0, '0, 1'b0);
    chk_ctl("t4.idle", 1'b1, 1'b0, 1'b0);

    // Instance 5: reset after the first of three PT blocks
    iv5 = 96'h0102030405060708090A0B0C;
    i_iv = iv5; i_aad_bits = '0; i_pt_bits = 64'd384; i_start = 1'b1;
    step();
    i_start = 1'b0;
    i_blk_valid = 1'b1; i_blk_data = blk[0]; step();
    chk_beat("t5.b0", 1'b1, 2'd1, '0, blk[0], {iv5, 32'h2}, 1'b1);
    rst = 1'b1; i_blk_data = blk[1]; step();
    rst = 1'b0; i_blk_valid = 1'b0; i_blk_data = '0;
    chk_beat("t5.rst", 1'b0, 2'd3, '0, '0, '0, 1'b0);
    chk_ctl("t5.rst", 1'b1, 1'b0, 1'b0);
    chk("t5.rst.j0", o_j0, '0);
    chk("t5.rst.size", o_instance_size, '0);
    step();
    chk_beat("t5.quiet", 1'b0, 2'd3, '0, '0, '0, 1'b0);
    i_pt_bits = 64'd128; i_start = 1'b1;
    step();
    i_start = 1'b0;
    i_blk_valid = 1'b1; i_blk_data = blk[4]; step();
    chk_beat("t5.fresh", 1'b1, 2'd1, '0, blk[4], {iv5, 32'h2}, 1'b1);
    i_blk_valid = 1'b0; i_blk_data = '0;
    step();
    chk_beat("t5.len", 1'b1, 2'd2, '0, '0, '0, 1'b0);
    step();
    chk_ctl("t5.idle", 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
